// File: rtl/series_datapath.sv
// Datapath for the truncated exp(x) series: sum of x^k/k!, k = 0..N_TERMS-1.
// Strobed by the series control unit; terms are Q2.14, x is Q0.16.
module series_datapath #(
    parameter int N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ldX,
    input  logic        ldTmp,
    input  logic        selTmp,
    input  logic [15:0] x_in,
    output logic [15:0] tmp_out,
    output logic [15:0] sum_out,
    output logic [3:0]  k_out,
    output logic        done
);

    localparam logic [3:0]  LAST = 4'(N_TERMS - 1);
    localparam logic [15:0] ONE  = 16'h4000;

    logic [15:0] x_reg, tmp, sum;
    logic [3:0]  k;
    logic        acc_en;

    logic [15:0] p1, p2;
    logic [16:0] recip, sum_wide;
    logic        step_ok;

    // floor(65536/j) in Q1.16
    function automatic logic [16:0] recip_of(input logic [3:0] j);
        case (j)
            4'd1:    recip_of = 17'h10000;
            4'd2:    recip_of = 17'h08000;
            4'd3:    recip_of = 17'h05555;
            4'd4:    recip_of = 17'h04000;
            4'd5:    recip_of = 17'h03333;
            4'd6:    recip_of = 17'h02AAA;
            4'd7:    recip_of = 17'h02492;
            4'd8:    recip_of = 17'h02000;
            4'd9:    recip_of = 17'h01C71;
            4'd10:   recip_of = 17'h01999;
            4'd11:   recip_of = 17'h01745;
            4'd12:   recip_of = 17'h01555;
            4'd13:   recip_of = 17'h013B1;
            4'd14:   recip_of = 17'h01249;
            4'd15:   recip_of = 17'h01111;
            default: recip_of = 17'h00000;
        endcase
    endfunction

    always_comb begin
        recip    = recip_of(k + 4'd1);
        p1       = 16'((32'(tmp) * 32'(x_reg)) >> 16);
        p2       = 16'((33'(p1) * 33'(recip)) >> 16);
        sum_wide = {1'b0, sum} + {1'b0, tmp};
        step_ok  = !done && (k < LAST);
    end

    // Accumulation trails the term load by one cycle; ldX overrides it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg  <= '0;
            tmp    <= '0;
            sum    <= '0;
            k      <= '0;
            acc_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            acc_en <= 1'b0;
            if (acc_en) begin
                sum <= sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
                if (k == LAST) done <= 1'b1;
            end
            if (ldX) begin
                x_reg <= x_in;
                sum   <= '0;
                k     <= '0;
                done  <= 1'b0;
            end else if (ldTmp && !selTmp) begin
                tmp    <= ONE;
                k      <= '0;
                acc_en <= 1'b1;
            end else if (ldTmp && step_ok) begin
                tmp    <= p2;
                k      <= k + 4'd1;
                acc_en <= 1'b1;
            end
        end
    end

    assign tmp_out = tmp;
    assign sum_out = sum;
    assign k_out   = k;

endmodule

// File: tb/tb_series_datapath.sv
// Bench for series_datapath: N_TERMS=8 and N_TERMS=15 instances, cycle model
// scoreboard plus directed constant checks.
module tb_series_datapath;

    logic clk, rst;
    logic a_ldx, a_ldtmp, a_sel, b_ldx, b_ldtmp, b_sel;
    logic [15:0] a_x, b_x, a_tmp, a_sum, b_tmp, b_sum;
    logic [3:0]  a_k, b_k;
    logic        a_done, b_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] x, tmp, sum;
        logic [3:0]  k;
        logic        acc, done;
    } st_t;

    st_t ma, mb;
    st_t qa[$];
    st_t qb[$];

    series_datapath #(.N_TERMS(8)) dut_a (
        .clk(clk), .rst(rst), .ldX(a_ldx), .ldTmp(a_ldtmp), .selTmp(a_sel),
        .x_in(a_x), .tmp_out(a_tmp), .sum_out(a_sum), .k_out(a_k), .done(a_done));

    series_datapath #(.N_TERMS(15)) dut_b (
        .clk(clk), .rst(rst), .ldX(b_ldx), .ldTmp(b_ldtmp), .selTmp(b_sel),
        .x_in(b_x), .tmp_out(b_tmp), .sum_out(b_sum), .k_out(b_k), .done(b_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t zero_st();
        st_t r;
        r.x = '0; r.tmp = '0; r.sum = '0; r.k = '0; r.acc = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    function automatic st_t nxt(st_t s, logic ldx, logic ldtmp, logic sel,
                                logic [15:0] x, int n);
        st_t r;
        logic [16:0] s17;
        logic [31:0] prod;
        logic [32:0] p2;
        int rc;
        r = s;
        r.acc = 1'b0;
        if (s.acc) begin
            s17 = {1'b0, s.sum} + {1'b0, s.tmp};
            r.sum = s17[16] ? 16'hFFFF : s17[15:0];
            if (int'(s.k) == n - 1) r.done = 1'b1;
        end
        if (ldx) begin
            r.x = x; r.sum = '0; r.k = '0; r.done = 1'b0;
        end else if (ldtmp && !sel) begin
            r.tmp = 16'h4000; r.k = '0; r.acc = 1'b1;
        end else if (ldtmp && !s.done && int'(s.k) < n - 1) begin
            prod = 32'(s.tmp) * 32'(s.x);
            rc = 65536 / (int'(s.k) + 1);
            p2 = 33'(prod[31:16]) * 33'(rc);
            r.tmp = p2[31:16];
            r.k = s.k + 4'd1;
            r.acc = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive the chosen instance, idle the other, compare both.
    task automatic step(input logic sel_b, input logic ldx, input logic ldtmp,
                        input logic sel, input logic [15:0] x);
        st_t ea, eb;
        @(negedge clk);
        a_ldx = sel_b ? 1'b0 : ldx;  a_ldtmp = sel_b ? 1'b0 : ldtmp;
        a_sel = sel_b ? 1'b0 : sel;  a_x = sel_b ? 16'h0 : x;
        b_ldx = sel_b ? ldx : 1'b0;  b_ldtmp = sel_b ? ldtmp : 1'b0;
        b_sel = sel_b ? sel : 1'b0;  b_x = sel_b ? x : 16'h0;
        ma = nxt(ma, a_ldx, a_ldtmp, a_sel, a_x, 8);
        mb = nxt(mb, b_ldx, b_ldtmp, b_sel, b_x, 15);
        qa.push_back(ma);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("sb_a_tmp", 32'(a_tmp), 32'(ea.tmp));
        chk("sb_a_sum", 32'(a_sum), 32'(ea.sum));
        chk("sb_a_k", 32'(a_k), 32'(ea.k));
        chk("sb_a_done", 32'(a_done), 32'(ea.done));
        chk("sb_b_tmp", 32'(b_tmp), 32'(eb.tmp));
        chk("sb_b_sum", 32'(b_sum), 32'(eb.sum));
        chk("sb_b_k", 32'(b_k), 32'(eb.k));
        chk("sb_b_done", 32'(b_done), 32'(eb.done));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tmp"}, 32'(a_tmp), 0);
        chk({tag, "_sum"}, 32'(a_sum), 0);
        chk({tag, "_k"}, 32'(a_k), 0);
        chk({tag, "_done"}, 32'(a_done), 0);
        chk({tag, "_b_sum"}, 32'(b_sum), 0);
    endtask

    initial begin
        rst = 1'b0;
        a_ldx = 0; a_ldtmp = 0; a_sel = 0; a_x = '0;
        b_ldx = 0; b_ldtmp = 0; b_sel = 0; b_x = '0;
        ma = zero_st();
        mb = zero_st();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // x = 0.5 worked series
        step(0, 1, 0, 0, 16'h8000);
        step(0, 0, 1, 0, 16'h0);
        chk("w_tmp0", 32'(a_tmp), 32'h4000);
        step(0, 0, 1, 1, 16'h0);
        chk("w_tmp1", 32'(a_tmp), 32'h2000);
        chk("w_sum0", 32'(a_sum), 32'h4000);
        step(0, 0, 1, 1, 16'h0);
        chk("w_tmp2", 32'(a_tmp), 32'h0800);
        step(0, 0, 1, 1, 16'h0);
        chk("w_tmp3", 32'(a_tmp), 32'h0155);
        chk("w_k3", 32'(a_k), 3);
        step(0, 0, 1, 1, 16'h0);
        chk("w_sum3", 32'(a_sum), 32'h6955);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0);
        chk("w_k7", 32'(a_k), 7);
        chk("w_done_low", 32'(a_done), 0);
        idle();
        chk("w_done_rise", 32'(a_done), 1);

        // overrun after done
        step(0, 0, 1, 1, 16'h0);
        step(0, 0, 1, 1, 16'h0);
        chk("ovr_k", 32'(a_k), 7);
        chk("ovr_done", 32'(a_done), 1);

        // asynchronous reset mid-evaluation
        step(0, 1, 0, 0, 16'h8000);
        step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0);
        idle();
        chk("mid_k", 32'(a_k), 3);
        chk("mid_sum", 32'(a_sum), 32'h6955);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        ma = zero_st();
        mb = zero_st();
        @(negedge clk);
        rst = 1'b1;

        // x = 0
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 16'h0);
        idle();
        chk("x0_tmp", 32'(a_tmp), 0);
        chk("x0_sum", 32'(a_sum), 32'h4000);
        chk("x0_done", 32'(a_done), 1);

        // restart while done, with ldX/ldTmp conflict
        step(0, 1, 0, 0, 16'h4000);
        chk("rs_done", 32'(a_done), 0);
        chk("rs_sum", 32'(a_sum), 0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 1, 1, 1, 16'h4000);
        chk("cf_tmp", 32'(a_tmp), 32'h4000);
        chk("cf_k", 32'(a_k), 0);
        chk("cf_sum", 32'(a_sum), 0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 1, 16'h0);
        chk("rs_tmp1", 32'(a_tmp), 32'h1000);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 16'h0);
        idle();
        chk("rs_done_end", 32'(a_done), 1);

        // N_TERMS=15 full series with x just under 1.0
        step(1, 1, 0, 0, 16'hFFFF);
        step(1, 0, 1, 0, 16'h0);
        step(1, 0, 1, 1, 16'h0);
        chk("b_tmp1", 32'(b_tmp), 32'h3FFF);
        for (int i = 0; i < 13; i++) step(1, 0, 1, 1, 16'h0);
        chk("b_k14", 32'(b_k), 14);
        idle();
        chk("b_done", 32'(b_done), 1);

        // saturation: repeated 1.0 terms push the sum past 0xFFFF
        step(1, 1, 0, 0, 16'hFFFF);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 16'h0);
        idle();
        chk("sat_sum", 32'(b_sum), 32'hFFFF);
        step(1, 0, 1, 0, 16'h0);
        idle();
        chk("sat_hold", 32'(b_sum), 32'hFFFF);
        chk("sat_done", 32'(b_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/series_datapath.md
Name: series_datapath

Overview:
- Responder to the series control unit: consumes the `ldX`, `ldTmp` and `selTmp` strobes and returns `done`.
- Computes the truncated exponential series sum of x^k/k! for k = 0..N_TERMS-1, in unsigned fixed point.
- Each term is derived from the previous one by multiplying by x and then by 1/k. The accumulator sum is the block result.

Parameters:
- N_TERMS, 8, number of series terms including the constant term; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ldX  in  1  strobe: capture x_in and start a new evaluation.
- ldTmp  in  1  strobe: load the term register.
- selTmp  in  1  term source select when ldTmp=1: 0 = constant 1.0, 1 = next term.
- x_in  in  16  operand x, unsigned Q0.16 (range 0 to just under 1.0).
- tmp_out  out  16  current term, unsigned Q2.14.
- sum_out  out  16  accumulated sum, unsigned Q2.14, saturating.
- k_out  out  4  index of the term currently held in tmp.
- done  out  1  level: all N_TERMS terms have been accumulated.

Behaviour:
- Reset (rst=0, asynchronous): x_reg, tmp, sum, k, the acc_en flop and done all clear to 0. The block is released on the first rising clk edge after rst=1.
- Only the three strobes below have effect; when none is active, all registers hold.
- ldX=1: x_reg<=x_in, sum<=0, k<=0, acc_en<=0, done<=0.
  - ldX has priority: ldTmp in the same cycle is ignored.
- ldTmp=1, selTmp=0 (and ldX=0): tmp<=0x4000 (1.0), k<=0, acc_en<=1.
- ldTmp=1, selTmp=1 (and ldX=0, done=0, k<N_TERMS-1):
  - p1 = (tmp × x_reg) >> 16, using a 32-bit product, truncated.
  - p2 = (p1 × recip(k+1)) >> 16, truncated to 16 bits.
  - tmp<=p2, k<=k+1, acc_en<=1.
- ldTmp=1, selTmp=1 when done=1 or k=N_TERMS-1: ignored. tmp, k and sum hold and acc_en<=0.
- recip(j) is a 17-bit Q1.16 constant equal to floor(65536/j), for j=1..15.
  - recip(1)=0x10000, recip(2)=0x8000, recip(3)=0x5555, recip(4)=0x4000, recip(5)=0x3333, recip(6)=0x2AAA, recip(7)=0x2492, recip(8)=0x2000.
  - Values for j=9..15 follow the same formula.
- Accumulate stage, one cycle after each accepted ldTmp:
  - If acc_en=1: sum<=sat16(sum+tmp), where the sum is computed 17 bits wide and clamps to 0xFFFF on carry-out.
  - acc_en clears the cycle after it is set, unless a new ldTmp is accepted in that cycle.
- done: set on the same edge as the accumulation of the term with k=N_TERMS-1. It stays high until ldX or reset.
- Latency: ldTmp sampled at edge n → tmp and k_out valid after edge n; sum_out updated at edge n+1.
  - Back-to-back ldTmp (one per cycle) is legal: the accumulation pipeline sustains one term per cycle.
- selTmp is don't-care when ldTmp=0.
- Reset mid-evaluation: all state is lost and done=0. The control unit must reissue ldX.
- All outputs are direct register outputs, with no combinational paths from inputs to outputs.

Test Plan:
- Reset check: assert rst=0 mid-run (sum nonzero, k=3) → within the same cycle tmp_out, sum_out, k_out and done read 0, with no clock edge needed.
- Worked series, N_TERMS=8: ldX with x_in=0x8000, then ldTmp/selTmp=0, then 7× ldTmp/selTmp=1 one per cycle.
  - tmp sequence: 0x4000, 0x2000, 0x0800, 0x0155, ...
  - sum after term 3 = 0x6955.
  - done rises exactly one cycle after the 8th ldTmp (k_out=7).
- x_in=0: init then 7 next-term loads → tmp=0 from k=1 on, sum_out=0x4000 final, done=1.
- Conflict and overrun:
  - ldX and ldTmp asserted together → only ldX takes effect (k=0, sum=0, tmp unchanged).
  - After done=1, further ldTmp/selTmp=1 → tmp, k and sum unchanged, done stays 1.
- Saturation, N_TERMS=15 with forced x_in=0xFFFF: the unclamped total would exceed 0xFFFF (force a large tmp) → sum_out clamps at 0xFFFF and never wraps.
- Restart: ldX while done=1 → done falls after the next edge, sum=0; a second evaluation with x_in=0x4000 reproduces golden-model values bit-exactly.
